// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the configurable UART receiver:
//                FSM state encoding, parity mode codes, baud divider math.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver FSM states, explicitly 3 bits wide
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

    // Parity mode codes
    localparam int c_par_none = 0;
    localparam int c_par_odd  = 1;
    localparam int c_par_even = 2;

    // Rounded hwclk cycles per sample tick: round(clk_hz / (baud * oversample))
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        int denom;
        denom = baud * oversample;
        return (clk_hz + denom / 2) / denom;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Sample-tick generator. Emits a one-cycle tick every DIV
//                hwclk cycles; restart re-phases the counter to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV = 78
) (
    input  logic hwclk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int                 c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_tick;

    // Free-running divider; restart suppresses the tick and re-phases the count
    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (restart) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == c_last) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_cfg
//  Description : Configurable UART receiver: oversampled start detection,
//                3-sample majority voting, optional parity, 1/2 stop bits,
//                valid/ready output holding register with overrun pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 hwclk,
    input  logic                 reset_n,
    input  logic                 rx,
    input  logic                 rx_en,
    output logic [DATA_BITS-1:0] rxbyte,
    output logic                 rxvalid,
    input  logic                 rxready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int                 c_div       = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int                 c_smp_w     = $clog2(OVERSAMPLE);
    // Tick numbers within a bit run 1..OVERSAMPLE; r_smp holds (tick number - 1)
    localparam logic [c_smp_w-1:0] c_smp_a     = c_smp_w'(OVERSAMPLE / 2 - 2);
    localparam logic [c_smp_w-1:0] c_smp_b     = c_smp_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_smp_w-1:0] c_smp_c     = c_smp_w'(OVERSAMPLE / 2);
    localparam logic [c_smp_w-1:0] c_smp_last  = c_smp_w'(OVERSAMPLE - 1);
    localparam int                 c_bit_w     = 4;
    localparam logic [c_bit_w-1:0] c_data_last = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_bit_w-1:0] c_stop_last = c_bit_w'(STOP_BITS - 1);

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic                 r_rx_prev;
    rx_state_t            r_state;
    logic [c_smp_w-1:0]   r_smp;
    logic                 r_skip;
    logic [c_bit_w-1:0]   r_bit;
    logic                 r_s0;
    logic                 r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_acc;
    logic                 r_ferr_acc;
    logic [DATA_BITS-1:0] r_rxbyte;
    logic                 r_rxvalid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    logic w_tick;
    logic w_start;
    logic w_sample;
    logic w_mid;
    logic w_vote;
    logic w_done;
    logic w_perr;

    // Start is a synchronized falling edge seen while idle and enabled
    assign w_start  = (r_state == ST_IDLE) && rx_en && r_rx_prev && !r_rx_sync;
    // r_skip masks the tail of the start bit after its early mid-bit decision
    assign w_sample = w_tick && !r_skip;
    assign w_mid    = w_sample && (r_smp == c_smp_c);
    assign w_vote   = (r_s0 & r_s1) | (r_s0 & r_rx_sync) | (r_s1 & r_rx_sync);
    assign w_done   = (r_state == ST_STOP) && w_mid && (r_bit == c_stop_last);
    // r_par_acc holds XOR of data bits and the received parity bit
    assign w_perr   = (PARITY == c_par_odd)  ? ~r_par_acc :
                      (PARITY == c_par_even) ?  r_par_acc : 1'b0;

    uart_baud_tick #(
        .DIV (c_div)
    ) u_tick (
        .hwclk   (hwclk),
        .reset_n (reset_n),
        .restart (w_start),
        .tick    (w_tick)
    );

    // Two-flop synchronizer plus one delayed copy for edge detection; idle high
    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Receive FSM with bit timing, voting, and the registered output stage
    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_smp        <= '0;
            r_skip       <= 1'b0;
            r_bit        <= '0;
            r_s0         <= 1'b1;
            r_s1         <= 1'b1;
            r_shift      <= '0;
            r_par_acc    <= 1'b0;
            r_ferr_acc   <= 1'b0;
            r_rxbyte     <= '0;
            r_rxvalid    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;

            if (r_rxvalid && rxready) begin
                r_rxvalid <= 1'b0;
            end
            if (w_done) begin
                if (!r_rxvalid || rxready) begin
                    r_rxbyte     <= r_shift;
                    r_frame_err  <= r_ferr_acc | ~w_vote;
                    r_parity_err <= w_perr;
                    r_rxvalid    <= 1'b1;
                end else begin
                    r_overrun    <= 1'b1;
                end
            end

            if (w_start) begin
                r_smp  <= '0;
                r_skip <= 1'b0;
            end else if (w_tick) begin
                if (r_smp == c_smp_last) begin
                    r_smp  <= '0;
                    r_skip <= 1'b0;
                end else begin
                    r_smp  <= r_smp + 1'b1;
                end
            end

            if (w_sample && (r_smp == c_smp_a)) r_s0 <= r_rx_sync;
            if (w_sample && (r_smp == c_smp_b)) r_s1 <= r_rx_sync;

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state    <= ST_START;
                        r_bit      <= '0;
                        r_par_acc  <= 1'b0;
                        r_ferr_acc <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_tick && (r_smp == c_smp_b)) begin
                        if (r_rx_sync) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_DATA;
                            r_skip  <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_mid) begin
                        r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
                        r_par_acc <= r_par_acc ^ w_vote;
                        if (r_bit == c_data_last) begin
                            r_bit   <= '0;
                            r_state <= (PARITY != c_par_none) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_mid) begin
                        r_par_acc <= r_par_acc ^ w_vote;
                        r_state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_mid) begin
                        r_ferr_acc <= r_ferr_acc | ~w_vote;
                        if (r_bit == c_stop_last) begin
                            r_bit   <= '0;
                            r_state <= r_rx_sync ? ST_IDLE : ST_WAIT_IDLE;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (r_rx_sync) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rxbyte     = r_rxbyte;
    assign rxvalid    = r_rxvalid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_cfg
//  Description : Directed bench for uart_rx_cfg. Instance A runs 8N1 with a
//                scoreboard of expected frames; instance B runs 8E1.
//                hwclk is scaled so one bit lasts 128 cycles (DIV = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

    localparam int c_clk_hz  = 1228800;
    localparam int c_baud    = 9600;
    localparam int c_bit_cyc = c_clk_hz / c_baud;   // 128 cycles per bit

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx_en;
    logic       rx_a,   rx_b;
    logic       rdy_a,  rdy_b;
    logic [7:0] byte_a, byte_b;
    logic       valid_a, valid_b;
    logic       ferr_a, ferr_b;
    logic       perr_a, perr_b;
    logic       ovr_a,  ovr_b;
    logic       busy_a, busy_b;

    exp_t sb_q[$];
    int   checks      = 0;
    int   errors      = 0;
    int   delivered_a = 0;
    int   ovr_cnt_a   = 0;
    int   ovr_cnt_b   = 0;

    uart_rx_cfg #(
        .CLK_HZ (c_clk_hz), .BAUD (c_baud), .OVERSAMPLE (16),
        .DATA_BITS (8), .PARITY (0), .STOP_BITS (1)
    ) u_dut_a (
        .hwclk (clk), .reset_n (rst_n), .rx (rx_a), .rx_en (rx_en),
        .rxbyte (byte_a), .rxvalid (valid_a), .rxready (rdy_a),
        .frame_err (ferr_a), .parity_err (perr_a), .overrun (ovr_a), .busy (busy_a)
    );

    uart_rx_cfg #(
        .CLK_HZ (c_clk_hz), .BAUD (c_baud), .OVERSAMPLE (16),
        .DATA_BITS (8), .PARITY (2), .STOP_BITS (1)
    ) u_dut_b (
        .hwclk (clk), .reset_n (rst_n), .rx (rx_b), .rx_en (rx_en),
        .rxbyte (byte_b), .rxvalid (valid_b), .rxready (rdy_b),
        .frame_err (ferr_b), .parity_err (perr_b), .overrun (ovr_b), .busy (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, landing 1 time unit after the active edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive n line bits LSB-first onto line A (to_b=0) or line B (to_b=1)
    task automatic send(input bit to_b, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (to_b) rx_b = bits[i];
            else      rx_a = bits[i];
            cyc(c_bit_cyc);
        end
    endtask

    function automatic logic [15:0] frame8n1(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    // Scoreboard consumer for instance A, plus overrun pulse counting
    always @(negedge clk) begin
        if (rst_n && valid_a && rdy_a) begin
            delivered_a++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_frame observed=%0h expected=none", byte_a);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("frame_a", {22'b0, byte_a, ferr_a, perr_a}, {22'b0, e});
            end
        end
        if (rst_n && ovr_a) ovr_cnt_a++;
        if (rst_n && ovr_b) ovr_cnt_b++;
    end

    initial begin
        #50_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        rst_n = 1'b0; rx_en = 1'b1;
        rx_a  = 1'b1; rx_b  = 1'b1;
        rdy_a = 1'b1; rdy_b = 1'b0;
        cyc(5);

        // Reset state
        chk("rst_valid",  {31'b0, valid_a}, 32'd0);
        chk("rst_byte",   {24'b0, byte_a},  32'd0);
        chk("rst_ferr",   {31'b0, ferr_a},  32'd0);
        chk("rst_perr",   {31'b0, perr_a},  32'd0);
        chk("rst_ovr",    {31'b0, ovr_a},   32'd0);
        chk("rst_busy",   {31'b0, busy_a},  32'd0);
        chk("rst_valid_b",{31'b0, valid_b}, 32'd0);
        rst_n = 1'b1;
        cyc(5);

        // 8N1 back-to-back frames with consumer always ready
        sb_q.push_back('{data: 8'h55, ferr: 1'b0, perr: 1'b0});
        send(1'b0, frame8n1(8'h55), 10);
        sb_q.push_back('{data: 8'hA3, ferr: 1'b0, perr: 1'b0});
        send(1'b0, frame8n1(8'hA3), 10);
        cyc(c_bit_cyc);
        chk("basic_count", delivered_a, 32'd2);

        // Low glitch of 3*DIV cycles is rejected at the start mid-sample
        rx_a = 1'b0;
        cyc(10);
        chk("glitch_busy_hi", {31'b0, busy_a}, 32'd1);
        cyc(14);
        rx_a = 1'b1;
        cyc(c_bit_cyc - 24);
        chk("glitch_busy_lo", {31'b0, busy_a}, 32'd0);
        chk("glitch_no_frame", delivered_a, 32'd2);

        // 8E1 on instance B: 0x0F with parity bit 1 is a parity error
        send(1'b1, {5'b0, 1'b1, 1'b1, 8'h0F, 1'b0}, 11);
        ok = 1'b0;
        for (int i = 0; i < 2 * c_bit_cyc; i++) begin
            if (valid_b) begin ok = 1'b1; break; end
            cyc(1);
        end
        chk("par_seen",  {31'b0, ok},     32'd1);
        chk("par_byte",  {24'b0, byte_b}, 32'h0F);
        chk("par_perr",  {31'b0, perr_b}, 32'd1);
        chk("par_ferr",  {31'b0, ferr_b}, 32'd0);
        rdy_b = 1'b1;
        cyc(1);
        rdy_b = 1'b0;
        chk("par_ack", {31'b0, valid_b}, 32'd0);
        // 0x07 with parity bit 1 gives even total parity: no error
        send(1'b1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        chk("par_ok_valid", {31'b0, valid_b}, 32'd1);
        chk("par_ok_byte",  {24'b0, byte_b},  32'h07);
        chk("par_ok_perr",  {31'b0, perr_b},  32'd0);
        chk("par_busy_b",   {31'b0, busy_b},  32'd0);
        rdy_b = 1'b1;
        cyc(1);
        rdy_b = 1'b0;

        // Stop bit forced low with line held low for 2 bit times (break)
        sb_q.push_back('{data: 8'h41, ferr: 1'b1, perr: 1'b0});
        send(1'b0, {7'b0, 8'h41, 1'b0}, 9);
        rx_a = 1'b0;
        cyc(2 * c_bit_cyc);
        chk("brk_busy_wait", {31'b0, busy_a}, 32'd1);
        chk("brk_delivered", delivered_a, 32'd3);
        rx_a = 1'b1;
        cyc(8);
        chk("brk_idle", {31'b0, busy_a}, 32'd0);

        // Consumer stalled: second frame is dropped with one overrun pulse
        rdy_a = 1'b0;
        sb_q.push_back('{data: 8'h11, ferr: 1'b0, perr: 1'b0});
        send(1'b0, frame8n1(8'h11), 10);
        send(1'b0, frame8n1(8'h22), 10);
        chk("ovr_valid", {31'b0, valid_a}, 32'd1);
        chk("ovr_hold",  {24'b0, byte_a},  32'h11);
        chk("ovr_pulses", ovr_cnt_a, 32'd1);
        rdy_a = 1'b1;
        cyc(2);
        chk("ovr_drained",   {31'b0, valid_a}, 32'd0);
        chk("ovr_delivered", delivered_a, 32'd4);

        // Reset during data bit 4 of 0x7E discards the partial frame
        send(1'b0, frame8n1(8'h7E), 5);
        rx_a = 1'b1;
        cyc(c_bit_cyc / 2);
        rst_n = 1'b0;
        cyc(4);
        chk("mid_rst_busy", {31'b0, busy_a}, 32'd0);
        rst_n = 1'b1;
        cyc(2 * c_bit_cyc);
        chk("post_rst_busy",     {31'b0, busy_a}, 32'd0);
        chk("post_rst_no_frame", delivered_a, 32'd4);
        sb_q.push_back('{data: 8'h33, ferr: 1'b0, perr: 1'b0});
        send(1'b0, frame8n1(8'h33), 10);
        cyc(c_bit_cyc);
        chk("final_delivered", delivered_a, 32'd5);
        chk("final_sb_empty",  sb_q.size(), 32'd0);
        chk("final_ovr_a",     ovr_cnt_a, 32'd1);
        chk("final_ovr_b",     ovr_cnt_b, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLK_HZ, default 12000000, SHALL give the hwclk frequency in Hz.
REQ-002 Parameter BAUD, default 9600, SHALL give the line rate in bit/s.
REQ-003 Parameter OVERSAMPLE, default 16, SHALL give the sample ticks per bit; it is even and at least 8.
REQ-004 Parameter DATA_BITS, default 8, SHALL give the data bits per frame; legal values are 5 to 9.
REQ-005 Parameter PARITY, default 0, SHALL select the parity mode: 0 none, 1 odd, 2 even.
REQ-006 Parameter STOP_BITS, default 1, SHALL give the number of stop bits; legal values are 1 and 2.
REQ-007 hwclk  in  1  SHALL be the single clock for all logic.
REQ-008 reset_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-009 rx  in  1  SHALL be the asynchronous serial line, idle high.
REQ-010 rx_en  in  1  SHALL permit new start bits to be accepted while high.
REQ-011 rxbyte  out  DATA_BITS  SHALL carry the received data, LSB = first bit on the line.
REQ-012 rxvalid  out  1  SHALL indicate that rxbyte, frame_err and parity_err hold an unconsumed frame.
REQ-013 rxready  in  1  SHALL be the consumer acknowledge; a transfer occurs on a cycle where rxvalid and rxready are both high.
REQ-014 frame_err  out  1  SHALL flag a low stop bit in the held frame.
REQ-015 parity_err  out  1  SHALL flag a parity mismatch in the held frame; it is always 0 when PARITY=0.
REQ-016 overrun  out  1  SHALL pulse for one cycle when a completed frame is dropped.
REQ-017 busy  out  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-018 rx SHALL pass through a 2-flop synchronizer; all logic uses only the synchronized value.
REQ-019 The sample tick SHALL be a one-cycle pulse every DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)) hwclk cycles (78 at the defaults); the tick counter restarts at 0 on start detection.
REQ-020 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-021 IDLE->START SHALL occur on a synchronized high-to-low transition of rx while rx_en=1.
REQ-022 START SHALL re-sample rx at tick OVERSAMPLE/2; rx=1 returns the FSM to IDLE (glitch rejection, no outputs change), and rx=0 enters DATA.
REQ-023 Each data, parity and stop bit SHALL be the 2-of-3 majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
REQ-024 DATA SHALL shift in DATA_BITS bits LSB-first, then go to PARITY if PARITY!=0, else to STOP.
REQ-025 Parity SHALL be checked as follows: odd mode requires the XOR of data and parity bit = 1; even mode requires it = 0.
REQ-026 STOP SHALL sample STOP_BITS bits; frame_err is set if any stop bit samples 0.
REQ-027 After the last stop sample, if rx=0 the FSM SHALL enter WAIT_IDLE and stay there until rx=1 (break), then go to IDLE; otherwise it SHALL go directly to IDLE.
REQ-028 At the last stop-bit mid-sample the frame SHALL complete, and rxvalid SHALL rise on the next hwclk edge.
REQ-029 A frame with an error SHALL still be delivered, with its error flags set.
REQ-030 On completion with rxvalid=0 or with a transfer in the same cycle, the block SHALL load rxbyte and the flags and set rxvalid.
REQ-031 On completion while rxvalid=1 and rxready=0, the new frame SHALL be discarded, the held data kept, and overrun pulsed.
REQ-032 rxvalid SHALL clear on transfer; rxbyte and the flags hold their values until the next load.
REQ-033 Deasserting rx_en mid-frame SHALL NOT abort the frame; it only blocks the next start.

Reset
REQ-034 While reset_n=0 the block SHALL be in this state: FSM IDLE, counters 0, synchronizer flops 1, rxbyte 0, and rxvalid, frame_err, parity_err, overrun and busy all 0.
REQ-035 Reset mid-frame SHALL discard the partial frame; after reset release, the first accepted start SHALL be a fresh falling edge.

Structure
REQ-036 Package uart_pkg SHALL hold the FSM state enumeration, the PARITY mode constants and the DIV computation function.
REQ-037 The sample-tick generator SHALL be a separate sub-module, uart_baud_tick, with parameter DIV and ports hwclk, reset_n, restart and tick.

Verification
REQ-038 Defaults, rxready=1, send 8N1 0x55 then 0xA3 -> two rxvalid pulses with 0x55 then 0xA3, all error flags 0.
REQ-039 A low glitch of 3*DIV hwclk cycles on idle rx -> FSM returns to IDLE, no rxvalid, busy drops within one bit time.
REQ-040 PARITY=2, send 0x0F with parity bit 1 -> rxbyte=0x0F, parity_err=1, rxvalid=1.
REQ-041 Send 0x41 with the stop bit forced 0 and rx held low 2 bit times -> frame_err=1, FSM waits in WAIT_IDLE until rx=1.
REQ-042 rxready=0, send 0x11 then 0x22 -> rxbyte stays 0x11, overrun pulses once at the second stop; rxready=1 then transfers 0x11.
REQ-043 Assert reset_n=0 during data bit 4 of 0x7E, release, send 0x33 -> only 0x33 is delivered.
